// File: rtl/datapath_gen2_if.sv
// Controller-to-datapath bundle: operand selects, load strobes, immediates and results.
// Latency: none (plain wires between controller and datapath).
// Backpressure: none on the bus itself; mul_busy/mul_done tell the controller when C is owned by the multiplier.
interface datapath_gen2_if #(
   parameter int W     = 16,
   parameter int NREGS = 8,
   parameter int PCW   = 8
);
   localparam int RA = $clog2(NREGS);

   logic          write;
   logic [RA-1:0] writenum;
   logic [RA-1:0] readA;
   logic [RA-1:0] readB;
   logic          loada;
   logic          loadb;
   logic          loadc;
   logic          loads;
   logic          asel;
   logic          bsel;
   logic [1:0]    vsel;
   logic [1:0]    ALUop;
   logic [1:0]    shift;
   logic [PCW-1:0] PC;
   logic [W-1:0]  mdata;
   logic [W-1:0]  sximm5;
   logic [W-1:0]  sximm8;
   logic          mul_start;
   logic          mul_busy;
   logic          mul_done;
   logic [W-1:0]  datapath_out;
   logic [2:0]    Z_out;

   // controller side
   modport master (
      output write, writenum, readA, readB, loada, loadb, loadc, loads,
      output asel, bsel, vsel, ALUop, shift, PC, mdata, sximm5, sximm8, mul_start,
      input  mul_busy, mul_done, datapath_out, Z_out
   );

   // datapath side
   modport slave (
      input  write, writenum, readA, readB, loada, loadb, loadc, loads,
      input  asel, bsel, vsel, ALUop, shift, PC, mdata, sximm5, sximm8, mul_start,
      output mul_busy, mul_done, datapath_out, Z_out
   );
endinterface

// File: rtl/datapath_gen2.sv
// CPU datapath: regfile, shifter, ALU, A/B/C/status registers, optional shift-add multiplier (DATAPATH_GEN2_MUL_EN).
// Latency: regfile write and A/B/C/status loads take one clock; a multiply takes W+1 clocks from mul_start to mul_done.
// Backpressure: while the multiplier owns C (busy or done cycle) loadc, loads and mul_start are ignored.
module datapath_gen2 #(
   parameter int W     = 16,
   parameter int NREGS = 8,
   parameter int PCW   = 8
) (
   input logic clk,
   input logic reset,
   datapath_gen2_if.slave dp
);
   localparam int RA = $clog2(NREGS);

   logic [W-1:0] regs [NREGS];
   logic [W-1:0] reg_a;
   logic [W-1:0] reg_b;
   logic [W-1:0] reg_c;
   logic [2:0]   status;

   logic [W-1:0] read_a;
   logic [W-1:0] read_b;
   logic [W-1:0] wb_data;
   logic [W-1:0] sh_out;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [W-1:0] alu_res;
   logic         alu_v;

   // multiplier hooks into the C/status update path
   logic         mul_wr;
   logic         mul_block;
   logic [W-1:0] mul_prod;

   // combinational reads; a same-cycle write is not forwarded
   assign read_a = regs[dp.readA];
   assign read_b = regs[dp.readB];

   // write-back source selection
   always_comb begin
      wb_data = reg_c;
      case (dp.vsel)
         2'b00:   wb_data = reg_c;
         2'b01:   wb_data = W'(dp.PC);
         2'b10:   wb_data = dp.sximm8;
         default: wb_data = dp.mdata;
      endcase
   end

   // register file: synchronous write, cleared on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (dp.write) begin
         regs[dp.writenum] <= wb_data;
      end
   end

   // operand registers A and B
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_a <= '0;
         reg_b <= '0;
      end else begin
         if (dp.loada) reg_a <= read_a;
         if (dp.loadb) reg_b <= read_b;
      end
   end

   // shifter on register B
   always_comb begin
      sh_out = reg_b;
      case (dp.shift)
         2'b00:   sh_out = reg_b;
         2'b01:   sh_out = {reg_b[W-2:0], 1'b0};
         2'b10:   sh_out = {1'b0, reg_b[W-1:1]};
         default: sh_out = {reg_b[W-1], reg_b[W-1:1]};
      endcase
   end

   assign alu_a = dp.asel ? '0 : reg_a;
   assign alu_b = dp.bsel ? dp.sximm5 : sh_out;

   // ALU with signed-overflow detection from operand/result sign bits
   always_comb begin
      alu_res = '0;
      alu_v   = 1'b0;
      case (dp.ALUop)
         2'b00: begin
            alu_res = alu_a + alu_b;
            alu_v   = (alu_a[W-1] == alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
         end
         2'b01: begin
            alu_res = alu_a - alu_b;
            alu_v   = (alu_a[W-1] != alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
         end
         2'b10:   alu_res = alu_a & alu_b;
         default: alu_res = ~alu_b;
      endcase
   end

   // result register C and {V,N,Z} status; the multiplier write takes priority
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_c  <= '0;
         status <= '0;
      end else if (mul_wr) begin
         reg_c  <= mul_prod;
         status <= {1'b0, mul_prod[W-1], (mul_prod == '0)};
      end else begin
         if (dp.loadc && !mul_block) reg_c  <= alu_res;
         if (dp.loads && !mul_block) status <= {alu_v, alu_res[W-1], (alu_res == '0)};
      end
   end

`ifdef DATAPATH_GEN2_MUL_EN
   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

   mul_state_t   state;
   mul_state_t   state_nxt;
   logic [CW-1:0] count;
   logic [W-1:0] mcand;
   logic [W-1:0] mplier;
   logic [W-1:0] acc;
   logic [W-1:0] step_sum;

   // one partial product per RUN cycle, only low W bits are ever kept
   assign step_sum = mplier[0] ? (acc + mcand) : acc;
   assign mul_prod = step_sum;

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next state and handshake outputs
   always_comb begin
      state_nxt = state;
      mul_wr    = 1'b0;
      mul_block = 1'b0;
      case (state)
         IDLE: begin
            if (dp.mul_start) state_nxt = RUN;
         end
         RUN: begin
            mul_block = 1'b1;
            if (count == CW'(1)) begin
               mul_wr    = 1'b1;
               state_nxt = DONE;
            end
         end
         default: begin
            mul_block = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   // shift-add operand and accumulator registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (state == IDLE) begin
         if (dp.mul_start) begin
            mcand  <= alu_a;
            mplier <= alu_b;
            acc    <= '0;
            count  <= CW'(W);
         end
      end else if (state == RUN) begin
         acc    <= step_sum;
         mcand  <= {mcand[W-2:0], 1'b0};
         mplier <= {1'b0, mplier[W-1:1]};
         count  <= count - CW'(1);
      end
   end

   assign dp.mul_busy = (state == RUN);
   assign dp.mul_done = (state == DONE);
`else
   logic mul_start_unused;

   assign mul_start_unused = dp.mul_start;
   assign mul_wr           = 1'b0;
   assign mul_block        = 1'b0;
   assign mul_prod         = '0;
   assign dp.mul_busy      = 1'b0;
   assign dp.mul_done      = 1'b0;
`endif

   assign dp.datapath_out = reg_c;
   assign dp.Z_out        = status;
endmodule

// File: tb/tb_datapath_gen2.sv
// Bench for datapath_gen2: directed cases with literal expectations plus random traffic vs a behavioural model.
// The model predicts the state after each clock edge from the inputs presented in that cycle.
// Outputs are compared shortly after every rising edge; literal checks are taken at the falling edge.
`timescale 1ns/1ps
module tb_datapath_gen2;
   localparam int W     = 16;
   localparam int NREGS = 8;
   localparam int PCW   = 8;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   datapath_gen2_if #(.W(W), .NREGS(NREGS), .PCW(PCW)) dpi ();

   datapath_gen2 #(.W(W), .NREGS(NREGS), .PCW(PCW)) dut (
      .clk   (clk),
      .reset (reset),
      .dp    (dpi)
   );

   // behavioural model state
   logic [W-1:0] m_regs [NREGS];
   logic [W-1:0] m_a, m_b, m_c;
   logic [2:0]   m_s;
   int           m_pend;
   logic         m_done;
   logic [W-1:0] m_prod;

   int  errors = 0;
   int  checks = 0;
   bit  cmp_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_a = '0; m_b = '0; m_c = '0; m_s = '0;
      m_pend = 0; m_done = 1'b0; m_prod = '0;
   endtask

   // advance the model across one rising edge using the inputs currently applied
   task automatic model_step();
      logic [W-1:0] sh, ai, bi, res, wb, oc;
      logic         v, blocked;
      int           sa, sb, sr;
      int           smax, smin;
      if (reset) begin
         model_reset();
         return;
      end
      smax = 2 ** (W - 1) - 1;
      smin = -(2 ** (W - 1));
      case (dpi.shift)
         2'd0: sh = m_b;
         2'd1: sh = m_b << 1;
         2'd2: sh = m_b >> 1;
         default: sh = $signed(m_b) >>> 1;
      endcase
      ai = dpi.asel ? '0 : m_a;
      bi = dpi.bsel ? dpi.sximm5 : sh;
      sa = $signed(ai);
      sb = $signed(bi);
      v  = 1'b0;
      case (dpi.ALUop)
         2'd0: begin sr = sa + sb; res = W'(sr); v = (sr > smax) || (sr < smin); end
         2'd1: begin sr = sa - sb; res = W'(sr); v = (sr > smax) || (sr < smin); end
         2'd2: res = ai & bi;
         default: res = ~bi;
      endcase
      blocked = (m_pend > 0) || m_done;
      oc = m_c;
      case (dpi.vsel)
         2'd0: wb = oc;
         2'd1: wb = W'(dpi.PC);
         2'd2: wb = dpi.sximm8;
         default: wb = dpi.mdata;
      endcase
      if (dpi.loada) m_a = m_regs[dpi.readA];
      if (dpi.loadb) m_b = m_regs[dpi.readB];
      if (dpi.loadc && !blocked) m_c = res;
      if (dpi.loads && !blocked) m_s = {v, res[W-1], res == '0};
`ifdef DATAPATH_GEN2_MUL_EN
      m_done = 1'b0;
      if (m_pend > 0) begin
         m_pend--;
         if (m_pend == 0) begin
            m_c = m_prod;
            m_s = {1'b0, m_prod[W-1], m_prod == '0};
            m_done = 1'b1;
         end
      end
      if (!blocked && dpi.mul_start) begin
         m_pend = W;
         m_prod = W'(longint'(ai) * longint'(bi));
      end
`endif
      if (dpi.write) m_regs[dpi.writenum] = wb;
   endtask

   // per-cycle comparison of every output against the model
   always @(posedge clk) begin
      #2;
      if (cmp_en) begin
         chk("cyc_dp_out", dpi.datapath_out, m_c);
         chk("cyc_z_out", dpi.Z_out, m_s);
         chk("cyc_busy", dpi.mul_busy, m_pend > 0);
         chk("cyc_done", dpi.mul_done, m_done);
      end
   end

   task automatic idle();
      dpi.write = 0; dpi.writenum = '0; dpi.readA = '0; dpi.readB = '0;
      dpi.loada = 0; dpi.loadb = 0; dpi.loadc = 0; dpi.loads = 0;
      dpi.asel = 0; dpi.bsel = 0; dpi.vsel = 2'd0; dpi.ALUop = 2'd0; dpi.shift = 2'd0;
      dpi.PC = '0; dpi.mdata = '0; dpi.sximm5 = '0; dpi.sximm8 = '0; dpi.mul_start = 0;
   endtask

   task automatic step();
      model_step();
      @(negedge clk);
   endtask

   task automatic wr_imm(input int r, input logic [W-1:0] val);
      idle();
      dpi.write = 1; dpi.writenum = 3'(r); dpi.vsel = 2'd2; dpi.sximm8 = val;
      step();
   endtask

   task automatic ld(input int ra, input int rb);
      idle();
      dpi.readA = 3'(ra); dpi.readB = 3'(rb); dpi.loada = 1; dpi.loadb = 1;
      step();
   endtask

   task automatic alu(input logic as, input logic bs, input logic [1:0] sh, input logic [1:0] op,
                      input logic [W-1:0] imm5, input logic lc, input logic ls);
      idle();
      dpi.asel = as; dpi.bsel = bs; dpi.shift = sh; dpi.ALUop = op;
      dpi.sximm5 = imm5; dpi.loadc = lc; dpi.loads = ls;
      step();
   endtask

   initial begin
      int nd;
      reset = 1'b1;
      idle();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst_dp_out", dpi.datapath_out, 16'h0000);
      chk("rst_z_out", dpi.Z_out, 3'b000);
      chk("rst_busy", dpi.mul_busy, 1'b0);
      chk("rst_done", dpi.mul_done, 1'b0);
      reset = 1'b0;
      cmp_en = 1'b1;

      // reset in the middle of an operation, then write/shift/add
      wr_imm(3, 16'h1111);
      ld(3, 3);
      idle(); dpi.loadc = 1; dpi.loads = 1; dpi.ALUop = 2'd0;
      reset = 1'b1;
      step();
      chk("midrst_c", dpi.datapath_out, 16'h0000);
      reset = 1'b0;
      wr_imm(3, 16'h0042);
      ld(0, 3);
      alu(1, 0, 2'b01, 2'b00, '0, 1, 1);
      chk("t1_c", dpi.datapath_out, 16'h0084);
      chk("t1_z", dpi.Z_out, 3'b000);

      // signed overflow on add; zero on sub
      wr_imm(1, 16'h7FFF);
      wr_imm(2, 16'h0001);
      ld(1, 2);
      alu(0, 0, 2'b00, 2'b00, '0, 1, 1);
      chk("t2_add_c", dpi.datapath_out, 16'h8000);
      chk("t2_add_z", dpi.Z_out, 3'b110);
      wr_imm(1, 16'h1234);
      wr_imm(2, 16'h1234);
      ld(1, 2);
      alu(0, 0, 2'b00, 2'b01, '0, 1, 1);
      chk("t2_sub_c", dpi.datapath_out, 16'h0000);
      chk("t2_sub_z", dpi.Z_out, 3'b001);

      // arithmetic and logical right shifts
      wr_imm(4, 16'h8002);
      ld(0, 4);
      alu(1, 0, 2'b11, 2'b00, '0, 1, 1);
      chk("t3_asr", dpi.datapath_out, 16'hC001);
      chk("t3_asr_z", dpi.Z_out, 3'b010);
      alu(1, 0, 2'b10, 2'b00, '0, 1, 1);
      chk("t3_lsr", dpi.datapath_out, 16'h4001);

      // same-cycle write/read returns the old value
      wr_imm(5, 16'h1357);
      idle();
      dpi.write = 1; dpi.writenum = 3'd5; dpi.vsel = 2'd2; dpi.sximm8 = 16'h2468;
      dpi.readA = 3'd5; dpi.loada = 1;
      step();
      alu(0, 1, 2'b00, 2'b00, '0, 1, 0);
      chk("t4_old", dpi.datapath_out, 16'h1357);
      ld(5, 0);
      alu(0, 1, 2'b00, 2'b00, '0, 1, 0);
      chk("t4_new", dpi.datapath_out, 16'h2468);
      idle();
      dpi.write = 1; dpi.writenum = 3'd5; dpi.vsel = 2'd1; dpi.PC = 8'hA5;
      step();
      ld(5, 0);
      alu(0, 1, 2'b00, 2'b00, '0, 1, 0);
      chk("t4_pc", dpi.datapath_out, 16'h00A5);

`ifdef DATAPATH_GEN2_MUL_EN
      // multiply 300*7, stray loadc and mul_start while busy
      wr_imm(1, 16'd300);
      wr_imm(2, 16'd7);
      ld(1, 2);
      idle(); dpi.mul_start = 1;
      step();
      for (int k = 1; k <= W; k++) begin
         chk("t5_busy", dpi.mul_busy, 1'b1);
         chk("t5_nodone", dpi.mul_done, 1'b0);
         idle();
         if (k == 5) begin dpi.loadc = 1; dpi.loads = 1; dpi.ALUop = 2'b11; end
         if (k == 3) dpi.mul_start = 1;
         step();
      end
      chk("t5_done", dpi.mul_done, 1'b1);
      chk("t5_busy_off", dpi.mul_busy, 1'b0);
      chk("t5_c", dpi.datapath_out, 16'd2100);
      chk("t5_z", dpi.Z_out, 3'b000);
      idle();
      step();
      chk("t5_done_pulse", dpi.mul_done, 1'b0);

      // reset in the middle of a multiply
      idle(); dpi.mul_start = 1;
      step();
      for (int k = 1; k <= 7; k++) begin
         idle();
         step();
      end
      reset = 1'b1;
      model_step();
      #1;
      chk("t6_busy", dpi.mul_busy, 1'b0);
      chk("t6_done", dpi.mul_done, 1'b0);
      chk("t6_c", dpi.datapath_out, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      nd = 0;
      repeat (20) begin
         idle();
         step();
         if (dpi.mul_done) nd++;
      end
      chk("t6_no_done", nd, 0);
`endif

      // random traffic against the model
      repeat (3000) begin
         dpi.write     = ($urandom_range(0, 2) != 0);
         dpi.writenum  = 3'($urandom);
         dpi.readA     = 3'($urandom);
         dpi.readB     = 3'($urandom);
         dpi.loada     = 1'($urandom);
         dpi.loadb     = 1'($urandom);
         dpi.loadc     = 1'($urandom);
         dpi.loads     = 1'($urandom);
         dpi.asel      = ($urandom_range(0, 3) == 0);
         dpi.bsel      = ($urandom_range(0, 3) == 0);
         dpi.vsel      = 2'($urandom);
         dpi.ALUop     = 2'($urandom);
         dpi.shift     = 2'($urandom);
         dpi.PC        = 8'($urandom);
         dpi.mdata     = 16'($urandom);
         dpi.sximm5    = 16'($signed(5'($urandom)));
         dpi.sximm8    = 16'($signed(8'($urandom)));
         dpi.mul_start = ($urandom_range(0, 7) == 0);
         reset         = ($urandom_range(0, 399) == 0);
         step();
      end
      reset = 1'b0;
      idle();
      step();
      cmp_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
